// File: rtl/keccak_round_seq_if.sv
// Handshake/status bundle between the padder/control FSM, the round sequencer
// and the Keccak-f[1600] datapath.
interface keccak_round_seq_if;
    logic        start;
    logic        advance;
    logic [23:0] round_onehot;
    logic [4:0]  round_idx;
    logic        busy;
    logic        last;
    logic        done;
    logic [63:0] rc;

    modport master (
        output start, advance,
        input  round_onehot, round_idx, busy, last, done, rc
    );

    modport slave (
        input  start, advance,
        output round_onehot, round_idx, busy, last, done, rc
    );
endinterface

// File: rtl/keccak_round_seq.sv
// Round sequencer for Keccak-f[1600]: one-hot/binary round, start/advance/done.
// Define KECCAK_RC_LFSR_EN to generate the 64-bit round constant from the 8-bit LFSR.
module keccak_round_seq #(
    parameter int unsigned NR = 24
) (
    input logic              clk,
    input logic              reset,
    keccak_round_seq_if.slave bus
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [4:0] LAST_IDX = 5'(NR - 1);

    state_t      state_q;
    logic [23:0] onehot_q;
    logic [4:0]  idx_q;
    logic        busy_q;
    logic        last_q;
    logic        done_q;
    logic [4:0]  idx_d;

    assign idx_d = idx_q + 5'd1;

`ifdef KECCAK_RC_LFSR_EN
    logic [7:0]  lfsr_q;
    logic [63:0] rc_q;
    logic [71:0] rc_start;
    logic [71:0] rc_d;

    // Seven LFSR steps per round; returns {lfsr after the round, round constant}.
    function automatic logic [71:0] rc_round(input logic [7:0] r_in);
        logic [7:0]  r;
        logic [63:0] rc;
        r  = r_in;
        rc = '0;
        for (int unsigned j = 0; j < 7; j++) begin
            rc[6'((1 << j) - 1)] = r[0];
            r = {r[6:0], 1'b0} ^ (r[7] ? 8'h71 : 8'h00);
        end
        return {r, rc};
    endfunction

    assign rc_start = rc_round(8'h01);
    assign rc_d     = rc_round(lfsr_q);
    assign bus.rc   = rc_q;
`else
    assign bus.rc   = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            onehot_q <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef KECCAK_RC_LFSR_EN
            lfsr_q   <= 8'h01;
            rc_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q  <= RUN;
                        onehot_q <= 24'h000001;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        last_q   <= (NR == 1);
`ifdef KECCAK_RC_LFSR_EN
                        // lfsr_q holds the state after the round currently presented.
                        lfsr_q   <= rc_start[71:64];
                        rc_q     <= rc_start[63:0];
`endif
                    end
                end
                RUN: begin
                    if (bus.advance) begin
                        if (idx_q == LAST_IDX) begin
                            state_q  <= IDLE;
                            onehot_q <= '0;
                            idx_q    <= '0;
                            busy_q   <= 1'b0;
                            last_q   <= 1'b0;
                            done_q   <= 1'b1;
`ifdef KECCAK_RC_LFSR_EN
                            rc_q     <= '0;
`endif
                        end else begin
                            onehot_q <= onehot_q << 1;
                            idx_q    <= idx_d;
                            last_q   <= (idx_d == LAST_IDX);
`ifdef KECCAK_RC_LFSR_EN
                            lfsr_q   <= rc_d[71:64];
                            rc_q     <= rc_d[63:0];
`endif
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.round_onehot = onehot_q;
    assign bus.round_idx    = idx_q;
    assign bus.busy         = busy_q;
    assign bus.last         = last_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_keccak_round_seq.sv
// Self-checking bench for keccak_round_seq; round constants come from the
// reference rc(t) bit-serial definition (checked when KECCAK_RC_LFSR_EN is defined).
module tb_keccak_round_seq;

    localparam int NR = 24;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    keccak_round_seq_if bus ();

    keccak_round_seq #(.NR(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference rc(t): 8-bit array LFSR with R[0] first, as in the Keccak reference.
    function automatic bit ref_rc_bit(int t);
        bit R [0:8];
        int n;
        n = t % 255;
        for (int k = 0; k < 9; k++) R[k] = 1'b0;
        R[0] = 1'b1;
        for (int i = 0; i < n; i++) begin
            for (int k = 8; k > 0; k--) R[k] = R[k-1];
            R[0] = 1'b0;
            R[0] = R[0] ^ R[8];
            R[4] = R[4] ^ R[8];
            R[5] = R[5] ^ R[8];
            R[6] = R[6] ^ R[8];
        end
        return R[0];
    endfunction

    function automatic logic [63:0] ref_rc(int r);
        logic [63:0] v;
        v = '0;
        for (int j = 0; j < 7; j++) v[6'((1 << j) - 1)] = ref_rc_bit(7 * r + j);
        return v;
    endfunction

    function automatic logic [63:0] known_rc(int r);
        case (r)
            0:       return 64'h0000000000000001;
            1:       return 64'h0000000000008082;
            2:       return 64'h800000000000808A;
            default: return 64'h8000000080008008;
        endcase
    endfunction

    // Expected output bundle; r < 0 means not running.
    function automatic logic [95:0] expv(int r, bit d);
        logic [63:0] rcx;
        rcx = '0;
        if (r < 0) return {24'h0, 5'h0, 1'b0, 1'b0, d, 64'h0};
`ifdef KECCAK_RC_LFSR_EN
        rcx = ref_rc(r);
`endif
        return {24'h1 << r, 5'(r), 1'b1, (r == NR - 1), 1'b0, rcx};
    endfunction

    function automatic logic [95:0] obs();
        return {bus.round_onehot, bus.round_idx, bus.busy, bus.last, bus.done, bus.rc};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b1;
        bus.advance = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== expv(-1, 0)) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=%h", obs(), expv(-1, 0));
        end
        reset = 1'b1;
        bus.start = 1'b0;
        bus.advance = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv(-1, 0)) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs(), expv(-1, 0));
            end
        end
    endtask

    task automatic test_full_run();
        int busy_cnt;
        busy_cnt = 0;
        bus.start = 1'b1;
        bus.advance = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (obs() !== expv(r, 0)) begin
                errors++;
                $display("FAIL full_run r=%0d got=%h exp=%h", r, obs(), expv(r, 0));
            end
`ifdef KECCAK_RC_LFSR_EN
            if (r == 0 || r == 1 || r == 2 || r == 23) begin
                checks++;
                if (bus.rc !== known_rc(r)) begin
                    errors++;
                    $display("FAIL known_rc r=%0d got=%h exp=%h", r, bus.rc, known_rc(r));
                end
            end
`endif
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        checks++;
        if (obs() !== expv(-1, 1)) begin
            errors++;
            $display("FAIL full_run_done got=%h exp=%h", obs(), expv(-1, 1));
        end
        bus.advance = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== expv(-1, 0)) begin
            errors++;
            $display("FAIL full_run_after got=%h exp=%h", obs(), expv(-1, 0));
        end
        checks++;
        if (busy_cnt != NR) begin
            errors++;
            $display("FAIL busy_cycles got=%0d exp=%0d", busy_cnt, NR);
        end
    endtask

    task automatic test_stall();
        int gap;
        int done_cnt;
        done_cnt = 0;
        bus.start = 1'b1;
        bus.advance = 1'b0;
        @(negedge clk);
        for (int r = 0; r < NR; r++) begin
            gap = $urandom_range(0, 7);
            for (int g = 0; g < gap; g++) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.advance = 1'b0;
                checks++;
                if (obs() !== expv(r, 0)) begin
                    errors++;
                    $display("FAIL stall_hold r=%0d g=%0d got=%h exp=%h", r, g, obs(), expv(r, 0));
                end
                @(negedge clk);
            end
            bus.start = 1'($urandom_range(0, 1));
            bus.advance = 1'b1;
            checks++;
            if (obs() !== expv(r, 0)) begin
                errors++;
                $display("FAIL stall_adv r=%0d got=%h exp=%h", r, obs(), expv(r, 0));
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.advance = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.done === 1'b1) done_cnt++;
            checks++;
            if (obs() !== expv(-1, i == 0)) begin
                errors++;
                $display("FAIL stall_end cyc=%0d got=%h exp=%h", i, obs(), expv(-1, i == 0));
            end
            @(negedge clk);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL stall_done_count got=%0d exp=1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bus.start = 1'b1;
        bus.advance = 1'b1;
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < NR; r++) begin
                checks++;
                if (obs() !== expv(r, 0)) begin
                    errors++;
                    $display("FAIL b2b p=%0d r=%0d got=%h exp=%h", p, r, obs(), expv(r, 0));
                end
                @(negedge clk);
            end
            checks++;
            if (obs() !== expv(-1, 1)) begin
                errors++;
                $display("FAIL b2b_done p=%0d got=%h exp=%h", p, obs(), expv(-1, 1));
            end
            if (p == 2) begin
                bus.start = 1'b0;
                bus.advance = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (obs() !== expv(-1, 0)) begin
            errors++;
            $display("FAIL b2b_idle got=%h exp=%h", obs(), expv(-1, 0));
        end
    endtask

    task automatic test_reset_mid_run();
        bus.start = 1'b1;
        bus.advance = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int r = 0; r < 10; r++) @(negedge clk);
        checks++;
        if (obs() !== expv(10, 0)) begin
            errors++;
            $display("FAIL mid_round10 got=%h exp=%h", obs(), expv(10, 0));
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs() !== expv(-1, 0)) begin
            errors++;
            $display("FAIL mid_async_clear got=%h exp=%h", obs(), expv(-1, 0));
        end
        @(negedge clk);
        checks++;
        if (obs() !== expv(-1, 0)) begin
            errors++;
            $display("FAIL mid_held got=%h exp=%h", obs(), expv(-1, 0));
        end
        reset = 1'b1;
        bus.advance = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== expv(-1, 0)) begin
            errors++;
            $display("FAIL mid_no_done got=%h exp=%h", obs(), expv(-1, 0));
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (obs() !== expv(0, 0)) begin
            errors++;
            $display("FAIL mid_restart got=%h exp=%h", obs(), expv(0, 0));
        end
        bus.advance = 1'b1;
        @(negedge clk);
        checks++;
        if (obs() !== expv(1, 0)) begin
            errors++;
            $display("FAIL mid_restart_r1 got=%h exp=%h", obs(), expv(1, 0));
        end
        bus.advance = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.advance = 1'b0;
        checks = 0;
        errors = 0;
        test_reset();
        test_full_run();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keccak_round_seq.md
Name: keccak_round_seq

Overview:
- Sequential round sequencer for the Keccak-f[1600] permutation core.
- Produces the one-hot round vector consumed by the round-constant decoder (24 bits, bit n = round n), plus a binary round index and start/advance/done handshakes.
- Optionally generates the 64-bit round constant itself from the standard 8-bit LFSR, so the permutation core can drop the combinational decoder.
- Sits between the padder/control FSM (start, done) and the f-permutation datapath (advance per round).

Parameters:
NR, 24, number of rounds per permutation; legal range 1..24; round vector bits above NR-1 are always 0.

Ports:
clk  input  1  clock, all flops on rising edge
reset  input  1  asynchronous, active-low reset; the only reset in the block
start  input  1  request a new permutation; accepted only in IDLE
advance  input  1  datapath finished the current round; sampled only in RUN
round_onehot  output  24  one-hot current round, registered; all-zero when not in RUN
round_idx  output  5  binary current round 0..NR-1; 0 when not in RUN
busy  output  1  high while in RUN
last  output  1  high in RUN when round_idx == NR-1
done  output  1  one-cycle pulse, the cycle after the final advance
rc  output  64  round constant for the current round (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, round_onehot=0, round_idx=0, busy=0, last=0, done=0, rc=0, LFSR=8'h01. All outputs are registered.
- States are IDLE and RUN.
- IDLE, start=1: the next edge enters RUN.
  - round_onehot=24'h000001, round_idx=0, busy=1, LFSR reloaded to 8'h01.
  - Latency from start to round 0 visible is 1 cycle.
- IDLE, start=0: hold; done is 0 except for the pulse cycle.
- RUN, advance=0: hold all outputs (stall of any length).
- RUN, advance=1, round_idx<NR-1: next edge shifts round_onehot left 1, increments round_idx, and advances the LFSR by 7 steps.
- RUN, advance=1, round_idx==NR-1: next edge returns to IDLE.
  - done=1 for exactly that cycle; round_onehot=0, round_idx=0, busy=0, last=0.
- start during RUN is ignored; it is not queued.
- start asserted in the done cycle is accepted (state is already IDLE), so back-to-back permutations have no gap cycle.
- last is registered: it is asserted together with round_onehot[NR-1].
- NR=1: the start edge asserts last immediately; the first advance produces done.
- Reset mid-RUN: asynchronous abort to the reset values; no done pulse.
- Invariant: in RUN, round_onehot has exactly one bit set, and round_onehot[round_idx]=1.

Optional Feature:
- Macro: KECCAK_RC_LFSR_EN.
- Defined: rc is generated internally.
  - 8-bit LFSR R, output bit = R[0].
  - Step: shift left 1; if the old R[7]=1, XOR 8'h71 into the result (taps x^8+x^6+x^5+x^4+1).
  - Per round, 7 unrolled steps yield bits b0..b6; rc[2^j-1]=b_j for j=0..6, and all other rc bits are 0.
  - rc is registered with round_onehot, so it is valid in the same cycle; rc=0 outside RUN.
- Undefined: rc is tied to 64'h0, no LFSR flops exist, and the consumer decodes round_onehot itself.
- All other behaviour is identical in both builds.

Test Plan:
- Reset with reset=0, then release; idle 5 cycles -> busy=0, done=0, round_onehot=0, rc=0, round_idx=0.
- start pulse, then advance held high -> round_onehot walks 0x000001..0x800000 over 24 cycles; last only on round 23; done pulses once on the next cycle; busy is high for exactly 24 cycles.
- Feature on, same run -> rc is 64'h1 at round 0, 64'h8082 at round 1, 64'h800000000000808A at round 2, and 64'h8000000080008008 at round 23.
- advance toggled randomly with gaps of up to 7 cycles -> outputs hold during gaps; rc and round_idx sequence is unchanged; exactly one done pulse.
- start held high continuously with advance=1 -> back-to-back permutations with no idle cycle; start pulses during RUN change nothing; rc restarts at 64'h1 each time.
- reset asserted at round 10 -> outputs clear asynchronously with no done pulse; a new start begins at round 0 with rc=64'h1.
